// File: rtl/seq_sort_engine.sv
// Sequential odd-even transposition sorter: loads N elements over a valid/ready stream,
// runs N compare-exchange passes (one per clock), then streams the sorted vector out.
module seq_sort_engine #(
  parameter int N     = 6,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_descend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_load_idx;
  logic [IW-1:0]    r_pass;
  logic [IW-1:0]    r_out_idx;
  logic             r_desc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_busy;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_buf  [N];
  logic [WIDTH-1:0] w_pass [N];
  logic [IW-1:0]    w_out_nxt;
  logic             w_in_xfer;

  assign w_in_xfer = (r_state == LOAD) && in_valid && r_in_ready;
  assign w_out_nxt = r_out_idx + 1'b1;

  // One compare-exchange pass: pairs starting at even indices on even passes, odd on odd.
  // Pairs are disjoint, so every pair can read the registered buffer directly.
  always_comb begin
    w_pass = r_buf;
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == r_pass[0]) begin
        if (r_desc ? (r_buf[i] < r_buf[i+1]) : (r_buf[i] > r_buf[i+1])) begin
          w_pass[i]   = r_buf[i+1];
          w_pass[i+1] = r_buf[i];
        end
      end
    end
  end

  // Element storage and direction are data: no reset, contents are don't-care after one.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_buf[r_load_idx] <= in_data;
      if (r_load_idx == '0) r_desc <= in_descend;
    end else if (r_state == SORT) begin
      r_buf <= w_pass;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_load_idx  <= '0;
      r_pass      <= '0;
      r_out_idx   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_xfer) begin
            if (r_load_idx == LAST) begin
              r_state    <= SORT;
              r_load_idx <= '0;
              r_pass     <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_load_idx <= r_load_idx + 1'b1;
            end
          end
        end
        SORT: begin
          r_pass <= r_pass + 1'b1;
          if (r_pass == LAST) begin
            // First output comes from the buffer as it will be after this final pass.
            r_state     <= DRAIN;
            r_out_idx   <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_pass[0];
            r_out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= LOAD;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_out_idx  <= w_out_nxt;
              r_out_data <= r_buf[w_out_nxt];
              r_out_last <= (w_out_nxt == LAST);
            end
          end
        end
        default: begin
          r_state     <= LOAD;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_sort_engine.sv
// Directed and randomized bench for seq_sort_engine; expected vectors come from
// queue sort()/rsort() of the loaded elements.
module tb_seq_sort_engine;

  localparam int N = 6;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_descend;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [W-1:0] vec[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_sort_engine #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_descend(in_descend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present vec[0..N-1]; optional random idle gaps between elements and a
  // flipped in_descend on every element after the first.
  task automatic load_vec(input bit desc, input int maxgap, input bit toggle);
    for (int i = 0; i < N; i++) begin
      if (i > 0 && maxgap > 0) begin
        int g;
        g = int'($urandom_range(maxgap));
        in_valid = 1'b0;
        repeat (g) tick();
      end
      in_valid   = 1'b1;
      in_data    = vec[i];
      in_descend = (i == 0) ? desc : (toggle ? ~desc : desc);
      check("in_ready_load", in_ready, 1);
      tick();
    end
    in_valid   = 1'b0;
    in_descend = 1'($urandom_range(1));
  endtask

  // mode 0: out_ready always 1; mode 1: pattern 1,0,0 repeating; mode 2: random.
  task automatic drain(input bit desc, input int mode);
    int lat;
    int j;
    int cyc;
    exp_q = vec;
    if (desc) exp_q.rsort();
    else      exp_q.sort();
    lat = 0;
    while (!out_valid && lat < 3 * N) begin
      check("busy_sort", busy, 1);
      check("in_ready_sort", in_ready, 0);
      tick();
      lat++;
    end
    check("latency", lat, N);
    j   = 0;
    cyc = 0;
    while (j < N && cyc < 8 * N) begin
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_q[j]);
      check("out_last", out_last, (j == N - 1));
      check("in_ready_drain", in_ready, 0);
      check("busy_drain", busy, 1);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      tick();
      if (out_ready) j++;
      cyc++;
    end
    check("drain_count", j, N);
    check("out_valid_after", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("busy_after", busy, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_descend = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Ascending, in_valid held high
    vec = '{8'd5, 8'd0, 8'd2, 8'd1, 8'd1, 8'd3};
    load_vec(1'b0, 0, 1'b0);
    drain(1'b0, 0);

    // Descending with in_descend flipped after element 0
    vec = '{8'd3, 8'd2, 8'd4, 8'd0, 8'd1, 8'd5};
    load_vec(1'b1, 0, 1'b1);
    drain(1'b1, 0);

    // Extremes and duplicates
    vec = '{8'd255, 8'd0, 8'd255, 8'd1, 8'd1, 8'd0};
    load_vec(1'b0, 0, 1'b0);
    drain(1'b0, 0);
    vec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd2};
    load_vec(1'b0, 0, 1'b0);
    drain(1'b0, 0);

    // Backpressure
    vec = '{8'd5, 8'd0, 8'd2, 8'd1, 8'd1, 8'd3};
    load_vec(1'b0, 0, 1'b0);
    drain(1'b0, 1);

    // Reset during the third SORT cycle
    vec = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6};
    load_vec(1'b0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_last", out_last, 0);
    for (int k = 0; k < 2 * N; k++) begin
      check("no_partial_out", out_valid, 0);
      tick();
    end
    vec = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};
    load_vec(1'b0, 0, 1'b0);
    drain(1'b0, 0);

    // Back-to-back vectors with random input gaps
    vec = '{8'd17, 8'd3, 8'd99, 8'd3, 8'd250, 8'd42};
    load_vec(1'b0, 2, 1'b0);
    drain(1'b0, 0);
    vec = '{8'd7, 8'd128, 8'd64, 8'd0, 8'd7, 8'd200};
    load_vec(1'b1, 2, 1'b0);
    drain(1'b1, 2);

    // Randomized vectors, direction and backpressure
    for (int r = 0; r < 6; r++) begin
      bit d;
      d = 1'($urandom_range(1));
      vec.delete();
      for (int i = 0; i < N; i++) vec.push_back(W'($urandom_range(255)));
      load_vec(d, 2, 1'b1);
      drain(d, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
